riscv_hazard_ctrl: RTL

Hazard and pipeline-sequencing controller for the 5-stage pipelined core. It watches register addresses and control bits from the D, E, M and W stages and drives the stall, flush and forwarding controls of the fetch, decode and execute pipeline registers. It also sequences data-memory wait states, with a timeout watchdog and stall/flush performance counters. The block is a single instance at core level, alongside the decode stage.

---
 rtl/riscv_hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/riscv_hazard_ctrl.sv
// Purpose: hazard and sequencing control for the 5-stage core (stall/flush/forward, dmem wait FSM, perf counters).
// Latency: stall/flush/forward are combinational (zero latency); counters and o_mem_err update one cycle after the event.
// Backpressure: a data-memory wait holds F/D/E/M and bubbles W until ack; redirect and load-use are suppressed meanwhile.
//
// Ports:
//   i_clk, i_rstn                  clock, async active-low reset
//   i_rs1_d/i_rs2_d                D-stage sources
//   i_rs1_e/i_rs2_e/i_rd_e         E-stage sources and destination
//   i_load_e, i_pc_src_e           E-stage load flag, taken redirect
//   i_rd_m/i_reg_write_m           M-stage writeback
//   i_rd_w/i_reg_write_w           W-stage writeback
//   i_dmem_req_m, i_dmem_ack       data-memory handshake
//   i_cnt_clr                      sync clear of counters and o_mem_err
//   o_stall_*/o_flush_*            pipeline register controls
//   o_fwd_a_e/o_fwd_b_e            E operand select (00 RF, 01 W, 10 M)
//   o_mem_err                      sticky memory timeout flag
//   o_stall_cnt/o_flush_cnt        performance counters
module riscv_hazard_ctrl #(
  parameter int P_TO_W        = 8,
  parameter int P_MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [4:0]  i_rs1_d,
  input  logic [4:0]  i_rs2_d,
  input  logic [4:0]  i_rs1_e,
  input  logic [4:0]  i_rs2_e,
  input  logic [4:0]  i_rd_e,
  input  logic        i_load_e,
  input  logic        i_pc_src_e,
  input  logic [4:0]  i_rd_m,
  input  logic        i_reg_write_m,
  input  logic [4:0]  i_rd_w,
  input  logic        i_reg_write_w,
  input  logic        i_dmem_req_m,
  input  logic        i_dmem_ack,
  input  logic        i_cnt_clr,
  output logic        o_stall_f,
  output logic        o_stall_d,
  output logic        o_stall_e,
  output logic        o_stall_m,
  output logic        o_flush_d,
  output logic        o_flush_e,
  output logic        o_flush_w,
  output logic [1:0]  o_fwd_a_e,
  output logic [1:0]  o_fwd_b_e,
  output logic        o_mem_err,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [P_TO_W-1:0] L_TIMEOUT = P_TO_W'(P_MEM_TIMEOUT);

  state_t            state;
  logic [P_TO_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              load_use;
  logic              stall_evt;
  logic              flush_evt;

  // Once waiting, only the ack matters: the M register is held, so req is
  // implied even if the requester drops it.
  always_comb begin
    mem_stall = 1'b0;
    if (state == RUN) mem_stall = i_dmem_req_m & ~i_dmem_ack;
    else              mem_stall = ~i_dmem_ack;
  end

  assign load_use = i_load_e & (i_rd_e != 5'd0) &
                    ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));

  // Redirect wins over load-use: the stalled D instruction is being flushed anyway.
  assign stall_evt = mem_stall | (load_use & ~i_pc_src_e);
  assign flush_evt = ~mem_stall & i_pc_src_e;

  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_stall_m = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_w = 1'b0;
    o_fwd_a_e = 2'b00;
    o_fwd_b_e = 2'b00;
    if (i_rstn) begin
      if (mem_stall) begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_stall_e = 1'b1;
        o_stall_m = 1'b1;
        o_flush_w = 1'b1;
      end else if (i_pc_src_e) begin
        o_flush_d = 1'b1;
        o_flush_e = 1'b1;
      end else if (load_use) begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_flush_e = 1'b1;
      end

      // M is the younger producer, so it takes priority over W; x0 never forwards.
      if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs1_e))
        o_fwd_a_e = 2'b10;
      else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs1_e))
        o_fwd_a_e = 2'b01;

      if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs2_e))
        o_fwd_b_e = 2'b10;
      else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs2_e))
        o_fwd_b_e = 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= RUN;
      wait_cnt  <= '0;
      o_mem_err <= 1'b0;
    end else begin
      if (i_cnt_clr) o_mem_err <= 1'b0;
      case (state)
        RUN: begin
          if (i_dmem_req_m && !i_dmem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= P_TO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (i_dmem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == L_TIMEOUT) begin
            state <= ERR;
            if (!i_cnt_clr) o_mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + P_TO_W'(1);
          end
        end
        ERR: begin
          // Keep stalling until the memory finally answers.
          if (i_dmem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= 32'd0;
      o_flush_cnt <= 32'd0;
    end else if (i_cnt_clr) begin
      o_stall_cnt <= 32'd0;
      o_flush_cnt <= 32'd0;
    end else begin
      if (stall_evt) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (flush_evt) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end

endmodule
